// File: rtl/pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_adder                                              |
// | Description : WIDTH-bit adder split into STAGES equal slices, one slice    |
// |               summed per stage with a registered carry between stages.     |
// |               Valid/ready on both sides, full throughput, stall-safe.      |
// | Options     : define PA_SUB_EN to add the 'sub' port (a - b - cin mode).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_adder: STAGES must be 1..WIDTH and divide WIDTH");
    end
  endgenerate

  // Stage registers: stage k holds the result slices 0..k, the operands
  // (upper slices still to be summed) and the carry out of slice k.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;

  // Next-state values for every stage, computed from the stage upstream.
  logic [STAGES-1:0]            v_nxt;
  logic [STAGES-1:0]            c_nxt;
  logic [STAGES-1:0][WIDTH-1:0] a_nxt;
  logic [STAGES-1:0][WIDTH-1:0] b_nxt;
  logic [STAGES-1:0][WIDTH-1:0] s_nxt;

  logic [STAGES-1:0]            en;
  logic [WIDTH-1:0]             b_in;
  logic                         cin_in;

  // Subtraction is folded in once at the input: invert b, flip carry-in.
`ifdef PA_SUB_EN
  assign b_in   = b ^ {WIDTH{sub}};
  assign cin_in = cin ^ sub;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  // Stage k may load when any stage from k to the output is empty or the
  // consumer is taking the result; written flat so no bit depends on another.
  always_comb begin
    en = '0;
    for (int k = 0; k < STAGES; k++) begin
      en[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v_q[j]) en[k] = 1'b1;
      end
    end
  end

  assign in_ready = en[0];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] s_src;
      logic [WIDTH-1:0] s_new;
      logic             c_src;
      logic             v_src;
      logic [SLICE:0]   add;

      if (k == 0) begin : g_first
        assign a_src = a;
        assign b_src = b_in;
        assign s_src = '0;
        assign c_src = cin_in;
        assign v_src = in_valid;
      end else begin : g_next
        assign a_src = a_q[k-1];
        assign b_src = b_q[k-1];
        assign s_src = s_q[k-1];
        assign c_src = c_q[k-1];
        assign v_src = v_q[k-1];
      end

      assign add = {1'b0, a_src[k*SLICE +: SLICE]}
                 + {1'b0, b_src[k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, c_src};

      // Merge this stage's slice into the partial sum from upstream.
      always_comb begin
        s_new                    = s_src;
        s_new[k*SLICE +: SLICE]  = add[SLICE-1:0];
      end

      assign v_nxt[k] = v_src;
      assign c_nxt[k] = add[SLICE];
      assign a_nxt[k] = a_src;
      assign b_nxt[k] = b_src;
      assign s_nxt[k] = s_new;
    end
  endgenerate

  // Pipeline registers: each stage loads only when its enable is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= v_nxt[k];
          c_q[k] <= c_nxt[k];
          a_q[k] <= a_nxt[k];
          b_q[k] <= b_nxt[k];
          s_q[k] <= s_nxt[k];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  // Carry into the MSB is recovered as a^b^sum at that bit position.
  assign ovf       = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                   ^ s_q[STAGES-1][WIDTH-1] ^ c_q[STAGES-1];

  // Already-consumed operand slices are carried along but never read.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q};

endmodule
`default_nettype wire
